shift_add_multiplier: RTL and testbench
=======================================

Name: shift_add_multiplier

Overview:
Sequential fixed-point multiplier, the inverse direction of the team's bit-serial divider. Multiplies a Q10.10 unsigned value (divider quotient format) by a 3-bit unsigned integer (divider divisor format) using one shift-add step per cycle.
Uses the same handshake as the divider (in_valid-framed load, single-cycle out_valid) and terminates early. A bench can chain divider → multiplier for round-trip checks.

Parameters:
INT_W, 10, integer bits of in_data_1
FRAC_W, 10, fraction bits of in_data_1
MUL_W, 3, width of in_data_2
(derived, not overridable: A_W=INT_W+FRAC_W=20, P_W=A_W+MUL_W=23, I_W=INT_W+MUL_W=13)

Ports:
Interface (already decided): one clock; reset is asynchronous and active-high.
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  load strobe; may stay high several cycles
in_data_1  in  A_W  unsigned Q10.10 multiplicand
in_data_2  in  MUL_W  unsigned integer multiplier
out_valid  out  1  single-cycle result strobe
out_data  out  P_W  full product, unsigned Q13.10
out_int  out  I_W  product rounded half-up to an integer

Behaviour:
- Reset: asynchronous; state=IDLE; out_valid=0, out_data=0, out_int=0; all internal registers 0. Reset asserted mid-operation aborts the operation; no out_valid is produced for it.
- FSM states (package enum): IDLE, LOAD, MULT, OUT.
- IDLE: when in_valid=1, latch operands and go to LOAD.
- LOAD: while in_valid=1, latch operands every cycle (last value wins). When in_valid=0, go to MULT and do not latch.
- Registers: mcand_sh (A_W bits, multiplicand shifting right); addend (P_W bits, zero-extended in_data_2 shifting left); acc (P_W bits, cleared at each latch).
- MULT, one step per cycle:
  - if mcand_sh[0]=1, acc <= acc + addend;
  - mcand_sh <= mcand_sh>>1 and addend <= addend<<1;
  - if the shifted mcand_sh is 0, go to OUT.
  - If mcand_sh is already 0 on MULT entry, spend exactly 1 MULT cycle, make no add, then go to OUT.
- MULT cycle count: n = max(1, msb_index(in_data_1)+1). Maximum n = A_W = 20.
- Latency: call E0 the edge that samples in_valid=0 in LOAD. out_valid rises n edges after E0.
- OUT: lasts exactly 1 cycle.
  - out_valid=1 during OUT only.
  - out_data and out_int are registered on entry to OUT and held until the next OUT entry or reset.
  - Next state is always IDLE.
- Arithmetic:
  - The product never overflows: max is 0xFFFFF*7 = 0x6FFFF9, which fits in 23 bits.
  - out_int = (final acc + 2^(FRAC_W-1)) >> FRAC_W. Max is 7168, which fits I_W; no saturation is needed.
- in_valid while in MULT or OUT is ignored (no latch, no restart). A new transaction can start in IDLE one cycle after OUT.
- in_data_2=0: mcand_sh iteration still runs the full n cycles; result is 0.

Decomposition:
- Shared package: the state enum, INT_W/FRAC_W/MUL_W defaults, and derived widths A_W/P_W/I_W. The divider shares these widths.
- Single module; no sub-module is natural. The step datapath is one adder plus two shifters, kept inline.

Test Plan:
- Basic: in_data_1=20'h00A00 (2.5), in_data_2=3, in_valid high 1 cycle → out_data=23'h001E00 (7.5), out_int=8, out_valid rises 12 edges after E0, high for exactly 1 cycle.
- Zero multiplicand: in_data_1=0, in_data_2=5 → out_data=0, out_int=0, n=1.
- Max operands: in_data_1=20'hFFFFF, in_data_2=7 → out_data=23'h6FFFF9, out_int=7168, n=20.
- Multi-cycle load: in_valid high 3 cycles with in_data_1=20'h00400/20'h00800/20'h00C00, in_data_2=1/2/3 → last values used: out_data=23'h002400, out_int=9. in_valid pulsed during MULT → result unchanged, no second out_valid.
- Reset mid-MULT: assert rst at MULT cycle 5 of a 20'hFFFFF×7 job → all outputs 0 immediately, no out_valid. Then 20'h00400 (1.0) × 6 → out_data=23'h001800, out_int=6, n=11.
- Back-to-back with divider: drive the divider's quotient for 1000/7 into this block with in_data_2=7 → out_int=1000 and |out_data - 1000<<10| < 7.

Source files
------------

// File: rtl/shift_add_multiplier_pkg.sv
// rtl/shift_add_multiplier_pkg.sv - shared widths and FSM state type for the shift-add multiplier
// Purpose: default operand widths (shared with the bit-serial divider), the
// widths derived from them, and the multiplier FSM state enum.
package shift_add_multiplier_pkg;

    localparam int DEF_INT_W  = 10;                      // integer bits of the Q-format multiplicand
    localparam int DEF_FRAC_W = 10;                      // fraction bits of the Q-format multiplicand
    localparam int DEF_MUL_W  = 3;                       // width of the integer multiplier
    localparam int DEF_A_W    = DEF_INT_W + DEF_FRAC_W;  // multiplicand width
    localparam int DEF_P_W    = DEF_A_W + DEF_MUL_W;     // full product width
    localparam int DEF_I_W    = DEF_INT_W + DEF_MUL_W;   // rounded integer product width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MULT = 2'd2,
        OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential Q10.10 x 3-bit unsigned shift-add multiplier
// Purpose: multiplies an unsigned fixed-point multiplicand by a small unsigned
// integer, one shift-add step per cycle, stopping as soon as no multiplicand
// bits remain.
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous reset, active-high
//   in_valid   load strobe; operands latched every cycle it is high in IDLE/LOAD
//   in_data_1  unsigned Q(INT_W).(FRAC_W) multiplicand
//   in_data_2  unsigned integer multiplier
//   out_valid  single-cycle result strobe
//   out_data   full product, unsigned Q(INT_W+MUL_W).(FRAC_W)
//   out_int    product rounded half-up to an integer
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int INT_W  = DEF_INT_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int MUL_W  = DEF_MUL_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [INT_W+FRAC_W-1:0]   in_data_1,
    input  logic [MUL_W-1:0]          in_data_2,
    output logic                      out_valid,
    output logic [INT_W+FRAC_W+MUL_W-1:0] out_data,
    output logic [INT_W+MUL_W-1:0]    out_int
);

    localparam int A_W = INT_W + FRAC_W;
    localparam int P_W = A_W + MUL_W;
    localparam int I_W = INT_W + MUL_W;

    // Half an integer LSB in product units, for round-half-up.
    localparam logic [P_W-1:0] ROUND_HALF = P_W'(1) << (FRAC_W - 1);

    state_t         state;
    state_t         state_next;

    logic [A_W-1:0] mcand_sh;
    logic [P_W-1:0] addend;
    logic [P_W-1:0] acc;

    logic           latch_en;
    logic [A_W-1:0] mcand_next;
    logic [P_W-1:0] acc_next;
    logic           mult_done;

    // Step datapath: one conditional add and the two shifters.
    always_comb begin
        latch_en   = in_valid && ((state == IDLE) || (state == LOAD));
        mcand_next = mcand_sh >> 1;
        acc_next   = acc + (mcand_sh[0] ? addend : '0);
        // Early termination: once the shifted multiplicand is empty no further
        // add can occur. A zero multiplicand therefore still spends one cycle.
        mult_done  = (mcand_next == '0);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = LOAD;
            LOAD:    if (!in_valid) state_next = MULT;
            MULT:    if (mult_done) state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        out_valid = (state == OUT);
    end

    // Operand, accumulator and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_sh <= '0;
            addend   <= '0;
            acc      <= '0;
            out_data <= '0;
            out_int  <= '0;
        end else if (latch_en) begin
            mcand_sh <= in_data_1;
            addend   <= {{(P_W-MUL_W){1'b0}}, in_data_2};
            acc      <= '0;
        end else if (state == MULT) begin
            acc      <= acc_next;
            mcand_sh <= mcand_next;
            addend   <= addend << 1;
            // Results are captured on the step that enters OUT and held after.
            // The product cannot overflow P_W, so neither can the rounded sum.
            if (mult_done) begin
                out_data <= acc_next;
                out_int  <= I_W'((acc_next + ROUND_HALF) >> FRAC_W);
            end
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - self-checking bench for shift_add_multiplier
module tb_shift_add_multiplier;
    import shift_add_multiplier_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic [DEF_A_W-1:0]   in_data_1;
    logic [DEF_MUL_W-1:0] in_data_2;
    logic                 out_valid;
    logic [DEF_P_W-1:0]   out_data;
    logic [DEF_I_W-1:0]   out_int;

    int errors = 0;
    int checks = 0;

    shift_add_multiplier dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data_1 (in_data_1),
        .in_data_2 (in_data_2),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_int   (out_int)
    );

    always #5 clk = ~clk;

    // Reference model: plain arithmetic on the operands.
    function automatic longint model_prod(input logic [DEF_A_W-1:0] a, input logic [DEF_MUL_W-1:0] b);
        return longint'(a) * longint'(b);
    endfunction

    function automatic longint model_int(input longint p);
        return (p + (longint'(1) << (DEF_FRAC_W - 1))) >> DEF_FRAC_W;
    endfunction

    // Cycle count = number of significant bits of the multiplicand, at least 1.
    function automatic int model_n(input logic [DEF_A_W-1:0] a);
        int n = 0;
        longint t = longint'(a);
        while (t != 0) begin
            n++;
            t = t / 2;
        end
        return (n == 0) ? 1 : n;
    endfunction

    // Single-cycle load, then report edges from E0 to out_valid (-1 on timeout).
    task automatic run_job(input logic [DEF_A_W-1:0] a, input logic [DEF_MUL_W-1:0] b,
                           output int lat, output logic [DEF_P_W-1:0] p, output logic [DEF_I_W-1:0] r);
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_data_1 = a;
        in_data_2 = b;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_data_1 = DEF_A_W'($urandom);
        in_data_2 = DEF_MUL_W'($urandom);
        @(posedge clk);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        p = out_data;
        r = out_int;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data_1 = '0; in_data_2 = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (out_int !== '0) begin errors++; $display("FAIL reset_out_int got=%0d exp=0", out_int); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat; logic [DEF_P_W-1:0] p; logic [DEF_I_W-1:0] r;
        run_job(20'h00A00, 3'd3, lat, p, r);
        checks++; if (p !== 23'h001E00) begin errors++; $display("FAIL basic_data got=%h exp=001e00", p); end
        checks++; if (r !== 13'd8) begin errors++; $display("FAIL basic_int got=%0d exp=8", r); end
        checks++; if (lat !== 12) begin errors++; $display("FAIL basic_latency got=%0d exp=12", lat); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_width got=%b exp=0", out_valid); end
        checks++; if (out_data !== 23'h001E00) begin errors++; $display("FAIL basic_hold got=%h exp=001e00", out_data); end
    endtask

    task automatic test_zero_mcand();
        int lat; logic [DEF_P_W-1:0] p; logic [DEF_I_W-1:0] r;
        run_job(20'h00000, 3'd5, lat, p, r);
        checks++; if (p !== '0) begin errors++; $display("FAIL zero_data got=%h exp=0", p); end
        checks++; if (r !== '0) begin errors++; $display("FAIL zero_int got=%0d exp=0", r); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL zero_latency got=%0d exp=1", lat); end
    endtask

    task automatic test_max();
        int lat; logic [DEF_P_W-1:0] p; logic [DEF_I_W-1:0] r;
        run_job(20'hFFFFF, 3'd7, lat, p, r);
        checks++; if (p !== 23'h6FFFF9) begin errors++; $display("FAIL max_data got=%h exp=6ffff9", p); end
        checks++; if (r !== 13'd7168) begin errors++; $display("FAIL max_int got=%0d exp=7168", r); end
        checks++; if (lat !== 20) begin errors++; $display("FAIL max_latency got=%0d exp=20", lat); end
    endtask

    task automatic test_reset_mid_mult();
        int lat; int extra; logic [DEF_P_W-1:0] p; logic [DEF_I_W-1:0] r;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data_1 = 20'hFFFFF; in_data_2 = 3'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1; rst = 1'b1; #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rstmid_data got=%h exp=0", out_data); end
        checks++; if (out_int !== '0) begin errors++; $display("FAIL rstmid_int got=%0d exp=0", out_int); end
        @(posedge clk); #1; rst = 1'b0;
        extra = 0;
        repeat (30) begin @(posedge clk); #1; if (out_valid) extra++; end
        checks++; if (extra !== 0) begin errors++; $display("FAIL rstmid_no_valid got=%0d exp=0", extra); end
        run_job(20'h00400, 3'd6, lat, p, r);
        checks++; if (p !== 23'h001800) begin errors++; $display("FAIL rstmid_after_data got=%h exp=001800", p); end
        checks++; if (r !== 13'd6) begin errors++; $display("FAIL rstmid_after_int got=%0d exp=6", r); end
        checks++; if (lat !== 11) begin errors++; $display("FAIL rstmid_after_latency got=%0d exp=11", lat); end
    endtask

    task automatic test_multi_load();
        int lat; int extra;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data_1 = 20'h00400; in_data_2 = 3'd1;
        @(posedge clk); #1;
        in_data_1 = 20'h00800; in_data_2 = 3'd2;
        @(posedge clk); #1;
        in_data_1 = 20'h00C00; in_data_2 = 3'd3;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data_1 = 20'h12345; in_data_2 = 3'd7;
        @(posedge clk);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = k; break; end
            if (k == 3) begin in_valid = 1'b1; in_data_1 = 20'hABCDE; in_data_2 = 3'd5; end
            if (k == 4) in_valid = 1'b0;
        end
        checks++; if (out_data !== 23'h002400) begin errors++; $display("FAIL multiload_data got=%h exp=002400", out_data); end
        checks++; if (out_int !== 13'd9) begin errors++; $display("FAIL multiload_int got=%0d exp=9", out_int); end
        checks++; if (lat !== 12) begin errors++; $display("FAIL multiload_latency got=%0d exp=12", lat); end
        extra = 0;
        repeat (30) begin @(posedge clk); #1; if (out_valid) extra++; end
        checks++; if (extra !== 0) begin errors++; $display("FAIL multiload_second_valid got=%0d exp=0", extra); end
    endtask

    task automatic test_divider_roundtrip();
        int lat; logic [DEF_P_W-1:0] p; logic [DEF_I_W-1:0] r;
        longint q; longint diff;
        // Divider quotient of 1000/7 in Q10.10 (truncating).
        q = (longint'(1000) << DEF_FRAC_W) / 7;
        run_job(DEF_A_W'(q), 3'd7, lat, p, r);
        diff = longint'(p) - (longint'(1000) << DEF_FRAC_W);
        if (diff < 0) diff = -diff;
        checks++; if (r !== 13'd1000) begin errors++; $display("FAIL roundtrip_int got=%0d exp=1000", r); end
        checks++; if (!(diff < 7)) begin errors++; $display("FAIL roundtrip_err got=%0d exp=<7", diff); end
        checks++; if (p !== DEF_P_W'(q * 7)) begin errors++; $display("FAIL roundtrip_data got=%h exp=%h", p, DEF_P_W'(q * 7)); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [DEF_P_W-1:0] p; logic [DEF_I_W-1:0] r;
        logic [DEF_A_W-1:0] a; logic [DEF_MUL_W-1:0] b; logic [31:0] mask;
        longint ep;
        for (int i = 0; i < 40; i++) begin
            mask = (32'd1 << $urandom_range(0, DEF_A_W)) - 32'd1;
            a = DEF_A_W'($urandom & mask);
            b = (i % 8 == 0) ? 3'd0 : DEF_MUL_W'($urandom);
            ep = model_prod(a, b);
            run_job(a, b, lat, p, r);
            checks++; if (p !== DEF_P_W'(ep)) begin errors++; $display("FAIL rand_data a=%h b=%0d got=%h exp=%h", a, b, p, DEF_P_W'(ep)); end
            checks++; if (r !== DEF_I_W'(model_int(ep))) begin errors++; $display("FAIL rand_int a=%h b=%0d got=%0d exp=%0d", a, b, r, model_int(ep)); end
            checks++; if (lat !== model_n(a)) begin errors++; $display("FAIL rand_latency a=%h got=%0d exp=%0d", a, lat, model_n(a)); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_mcand();
        test_max();
        test_reset_mid_mult();
        test_multi_load();
        test_divider_roundtrip();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
